// File: rtl/iob_slave_buf.sv
// iob_slave_buf
// One generic buffered peripheral on the IO bus. It decodes its device
// code, executes CONO / DATAO / CONI / DATAI, holds a 36-bit output buffer
// and a 36-bit input buffer with valid/ready device sides, and raises a PI
// request on the channel loaded into pia. Bus bit 35 is the LSB.
module iob_slave_buf #(
   parameter logic [6:0] DEVCODE = 7'o070
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        iob_poweron,
   input  logic        iob_reset,
   input  logic        datao_clear,
   input  logic        datao_set,
   input  logic        cono_clear,
   input  logic        cono_set,
   input  logic        iob_fm_datai,
   input  logic        iob_fm_status,
   input  logic        rdi_pulse,
   input  logic [3:9]  ios,
   input  logic [0:35] iob_write,
   output logic [1:7]  pi_req,
   output logic [0:35] iob_read,
   output logic        dr_split,
   output logic        rdi_data,
   output logic [0:35] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   input  logic [0:35] in_data,
   input  logic        in_valid,
   output logic        in_ready
);

   // Architectural state
   logic [0:2]  pia_q, pia_d;
   logic        out_ie_q, out_ie_d;
   logic        in_ie_q, in_ie_d;
   logic        out_full_q, out_full_d;
   logic        in_full_q, in_full_d;
   logic [0:35] obuf_q, obuf_d;
   logic [0:35] ibuf_q, ibuf_d;

   // Previous values of the bus pulses, used for edge detection
   logic        dclr_q, dclr_d;
   logic        dset_q, dset_d;
   logic        cclr_q, cclr_d;
   logic        cset_q, cset_d;
   logic        datai_q, datai_d;

   logic        sel;
   logic        busClear;
   logic        dClrEdge, dSetEdge, cClrEdge, cSetEdge, dataiFall;
   logic        outTake, inTake;
   logic        irq;
   logic [0:35] statusWord;
   logic        unusedRdiPulse;

   // This device never services read-in, so that pulse is deliberately ignored
   assign unusedRdiPulse = rdi_pulse;

   // Device selection, bus pulse edges and handshake acceptance
   always_comb begin
      sel       = (ios == DEVCODE);
      busClear  = iob_reset | ~iob_poweron;
      dClrEdge  = sel & datao_clear & ~dclr_q;
      dSetEdge  = sel & datao_set & ~dset_q;
      cClrEdge  = sel & cono_clear & ~cclr_q;
      cSetEdge  = sel & cono_set & ~cset_q;
      dataiFall = sel & ~iob_fm_datai & datai_q;
      outTake   = out_full_q & out_ready;
      inTake    = ~in_full_q & in_valid;
   end

   // Next-state logic: clears apply before sets, and a new DATAO or an
   // accepted device word outranks anything that would empty that buffer
   always_comb begin
      pia_d    = cClrEdge ? 3'b000 : pia_q;
      out_ie_d = cClrEdge ? 1'b0 : out_ie_q;
      in_ie_d  = cClrEdge ? 1'b0 : in_ie_q;
      if (cSetEdge) begin
         pia_d    = pia_d | iob_write[33:35];
         out_ie_d = out_ie_d | iob_write[30];
         in_ie_d  = in_ie_d | iob_write[29];
      end

      obuf_d = dClrEdge ? '0 : obuf_q;
      if (dSetEdge) begin
         obuf_d = obuf_d | iob_write;
      end

      out_full_d = out_full_q;
      if (outTake || (cSetEdge && iob_write[32])) begin
         out_full_d = 1'b0;
      end
      if (dSetEdge) begin
         out_full_d = 1'b1;
      end

      in_full_d = in_full_q;
      ibuf_d    = ibuf_q;
      if ((cSetEdge && iob_write[31]) || dataiFall) begin
         in_full_d = 1'b0;
      end
      if (inTake) begin
         in_full_d = 1'b1;
         ibuf_d    = in_data;
      end

      dclr_d  = datao_clear;
      dset_d  = datao_set;
      cclr_d  = cono_clear;
      cset_d  = cono_set;
      datai_d = iob_fm_datai;

      if (busClear) begin
         pia_d      = 3'b000;
         out_ie_d   = 1'b0;
         in_ie_d    = 1'b0;
         obuf_d     = '0;
         out_full_d = 1'b0;
         ibuf_d     = '0;
         in_full_d  = 1'b0;
         dclr_d     = 1'b0;
         dset_d     = 1'b0;
         cclr_d     = 1'b0;
         cset_d     = 1'b0;
         datai_d    = 1'b0;
      end
   end

   // State register with asynchronous reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pia_q      <= 3'b000;
         out_ie_q   <= 1'b0;
         in_ie_q    <= 1'b0;
         obuf_q     <= '0;
         out_full_q <= 1'b0;
         ibuf_q     <= '0;
         in_full_q  <= 1'b0;
         dclr_q     <= 1'b0;
         dset_q     <= 1'b0;
         cclr_q     <= 1'b0;
         cset_q     <= 1'b0;
         datai_q    <= 1'b0;
      end else begin
         pia_q      <= pia_d;
         out_ie_q   <= out_ie_d;
         in_ie_q    <= in_ie_d;
         obuf_q     <= obuf_d;
         out_full_q <= out_full_d;
         ibuf_q     <= ibuf_d;
         in_full_q  <= in_full_d;
         dclr_q     <= dclr_d;
         dset_q     <= dset_d;
         cclr_q     <= cclr_d;
         cset_q     <= cset_d;
         datai_q    <= datai_d;
      end
   end

   // Outputs: bus reads, device handshakes and the one-hot PI request
   always_comb begin
      statusWord         = '0;
      statusWord[29]     = in_ie_q;
      statusWord[30]     = out_ie_q;
      statusWord[31]     = in_full_q;
      statusWord[32]     = out_full_q;
      statusWord[33:35]  = pia_q;

      iob_read = '0;
      if (sel && iob_fm_datai) begin
         iob_read = iob_read | ibuf_q;
      end
      if (sel && iob_fm_status) begin
         iob_read = iob_read | statusWord;
      end

      irq = (in_full_q & in_ie_q) | (~out_full_q & out_ie_q);
      pi_req = '0;
      for (int k = 1; k <= 7; k++) begin
         pi_req[k] = irq & (pia_q == 3'(k));
      end

      out_data  = obuf_q;
      out_valid = out_full_q;
      in_ready  = ~in_full_q;
      dr_split  = 1'b0;
      rdi_data  = 1'b0;
   end

endmodule
